// File: rtl/adc_scan_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module : adc_scan_ctrl_pkg
// Brief  : Shared channel geometry and FSM encoding for the ADC scan controller.
// Rev    : 1.0
// ============================================================================
package adc_scan_ctrl_pkg;

    localparam int c_NUM_CHAN = 8;
    localparam int c_CHAN_W   = 3;

    typedef logic [c_CHAN_W-1:0] chan_t;

    typedef enum logic [1:0] {
        ST_WAIT  = 2'd0,
        ST_CHECK = 2'd1,
        ST_EMIT  = 2'd2,
        ST_HOST  = 2'd3
    } state_t;

    // Channel pointer advances 0..7 and wraps naturally in 3 bits.
    function automatic chan_t next_chan(input chan_t c);
        return c + chan_t'(1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/adc_scan_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module : adc_scan_ctrl_if
// Brief  : ADC bank, host read and change-event signals of the scan controller.
// Rev    : 1.0
// ============================================================================
interface adc_scan_ctrl_if #(
    parameter int ADC_WIDTH = 8
);
    import adc_scan_ctrl_pkg::*;

    logic                 enable;
    chan_t                adc_addr;
    logic [ADC_WIDTH-1:0] adc_q;
    logic                 host_req;
    chan_t                host_addr;
    logic                 host_ack;
    logic [ADC_WIDTH-1:0] host_data;
    logic                 evt_valid;
    logic                 evt_ready;
    chan_t                evt_chan;
    logic [ADC_WIDTH-1:0] evt_value;

    modport slave (
        input  enable, adc_q, host_req, host_addr, evt_ready,
        output adc_addr, host_ack, host_data, evt_valid, evt_chan, evt_value
    );

    modport master (
        output enable, adc_q, host_req, host_addr, evt_ready,
        input  adc_addr, host_ack, host_data, evt_valid, evt_chan, evt_value
    );

endinterface
`default_nettype wire

// File: rtl/adc_scan_ctrl_tick_gen.sv
`default_nettype none
// ============================================================================
// Module : tick_gen
// Brief  : Poll-rate divider; one-cycle tick every SCAN_DIV enabled cycles.
// Rev    : 1.0
// ============================================================================
module tick_gen #(
    parameter int SCAN_DIV = 16000
) (
    input  wire logic clk,
    input  wire logic reset,
    input  wire logic enable,
    output logic      tick
);

    localparam int c_CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [c_CNT_W-1:0] c_TERM = c_CNT_W'(SCAN_DIV - 1);

    logic [c_CNT_W-1:0] r_count;
    logic               w_term;

    assign w_term = (r_count == c_TERM);
    assign tick   = enable & w_term;

    // Count freezes while disabled so the poll phase resumes where it left off.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (enable) begin
            r_count <= w_term ? '0 : r_count + c_CNT_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/adc_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module : adc_scan_ctrl
// Brief  : Round-robin ADC poller with hysteresis change events and host reads.
// Rev    : 1.0
// ============================================================================
module adc_scan_ctrl
    import adc_scan_ctrl_pkg::*;
#(
    parameter int ADC_WIDTH = 8,
    parameter int SCAN_DIV  = 16000,
    parameter int HYST      = 2
) (
    input  wire logic         clk,
    input  wire logic         reset,
    adc_scan_ctrl_if.slave    bus
);

    localparam logic [ADC_WIDTH:0] c_HYST = (ADC_WIDTH+1)'(HYST);

    state_t               r_state, w_state_nxt;
    chan_t                r_adc_addr, w_adc_addr_nxt;
    chan_t                r_scan_ptr, w_scan_ptr_nxt;
    logic                 r_pending, w_pending_nxt;
    logic [c_NUM_CHAN-1:0] r_seen;
    logic [ADC_WIDTH-1:0] r_last [c_NUM_CHAN];
    logic                 r_host_ack, w_host_ack_nxt;
    logic [ADC_WIDTH-1:0] r_host_data, w_host_data_nxt;
    logic                 r_evt_valid, w_evt_valid_nxt;
    chan_t                r_evt_chan, w_evt_chan_nxt;
    logic [ADC_WIDTH-1:0] r_evt_value, w_evt_value_nxt;
    logic                 w_tick;
    logic                 w_upd;
    logic [ADC_WIDTH:0]   w_q_ext, w_last_ext, w_diff;
    logic                 w_change;

    tick_gen #(
        .SCAN_DIV (SCAN_DIV)
    ) u_tick_gen (
        .clk    (clk),
        .reset  (reset),
        .enable (bus.enable),
        .tick   (w_tick)
    );

    // One extra bit keeps 0x00 vs 0xFF a full-scale change rather than 1.
    assign w_q_ext    = {1'b0, bus.adc_q};
    assign w_last_ext = {1'b0, r_last[r_scan_ptr]};
    assign w_diff     = (w_q_ext >= w_last_ext) ? (w_q_ext - w_last_ext)
                                                : (w_last_ext - w_q_ext);
    assign w_change   = !r_seen[r_scan_ptr] || (w_diff >= c_HYST);

    always_comb begin
        w_state_nxt     = r_state;
        w_adc_addr_nxt  = r_adc_addr;
        w_scan_ptr_nxt  = r_scan_ptr;
        w_pending_nxt   = r_pending | w_tick;
        w_upd           = 1'b0;
        w_host_ack_nxt  = 1'b0;
        w_host_data_nxt = r_host_data;
        w_evt_valid_nxt = r_evt_valid;
        w_evt_chan_nxt  = r_evt_chan;
        w_evt_value_nxt = r_evt_value;
        case (r_state)
            ST_WAIT: begin
                // Host outranks a pending poll; the ack cycle masks the held request.
                if (bus.host_req && !r_host_ack) begin
                    w_adc_addr_nxt = bus.host_addr;
                    w_state_nxt    = ST_HOST;
                end else if (r_pending) begin
                    w_adc_addr_nxt = r_scan_ptr;
                    w_pending_nxt  = w_tick;
                    w_state_nxt    = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (w_change) begin
                    w_upd           = 1'b1;
                    w_evt_valid_nxt = 1'b1;
                    w_evt_chan_nxt  = r_scan_ptr;
                    w_evt_value_nxt = bus.adc_q;
                    w_state_nxt     = ST_EMIT;
                end else begin
                    w_scan_ptr_nxt = next_chan(r_scan_ptr);
                    w_state_nxt    = ST_WAIT;
                end
            end
            ST_EMIT: begin
                if (r_evt_valid && bus.evt_ready) begin
                    w_evt_valid_nxt = 1'b0;
                    w_scan_ptr_nxt  = next_chan(r_scan_ptr);
                    w_state_nxt     = ST_WAIT;
                end
            end
            ST_HOST: begin
                w_host_data_nxt = bus.adc_q;
                w_host_ack_nxt  = 1'b1;
                w_state_nxt     = ST_WAIT;
            end
            default: w_state_nxt = ST_WAIT;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_WAIT;
            r_adc_addr  <= '0;
            r_scan_ptr  <= '0;
            r_pending   <= 1'b0;
            r_seen      <= '0;
            r_host_ack  <= 1'b0;
            r_host_data <= '0;
            r_evt_valid <= 1'b0;
            r_evt_chan  <= '0;
            r_evt_value <= '0;
            for (int i = 0; i < c_NUM_CHAN; i++) begin
                r_last[i] <= '0;
            end
        end else begin
            r_state     <= w_state_nxt;
            r_adc_addr  <= w_adc_addr_nxt;
            r_scan_ptr  <= w_scan_ptr_nxt;
            r_pending   <= w_pending_nxt;
            r_host_ack  <= w_host_ack_nxt;
            r_host_data <= w_host_data_nxt;
            r_evt_valid <= w_evt_valid_nxt;
            r_evt_chan  <= w_evt_chan_nxt;
            r_evt_value <= w_evt_value_nxt;
            if (w_upd) begin
                r_last[r_scan_ptr] <= bus.adc_q;
                r_seen[r_scan_ptr] <= 1'b1;
            end
        end
    end

    assign bus.adc_addr  = r_adc_addr;
    assign bus.host_ack  = r_host_ack;
    assign bus.host_data = r_host_data;
    assign bus.evt_valid = r_evt_valid;
    assign bus.evt_chan  = r_evt_chan;
    assign bus.evt_value = r_evt_value;

endmodule
`default_nettype wire

// File: tb/tb_adc_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_adc_scan_ctrl
// Brief  : Directed self-checking bench for adc_scan_ctrl (SCAN_DIV=4, HYST=2).
// Rev    : 1.0
// ============================================================================
module tb_adc_scan_ctrl;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;

    logic [7:0]  bank [8];
    logic [10:0] evq [$];
    logic [10:0] got;
    logic [10:0] exp;

    adc_scan_ctrl_if #(.ADC_WIDTH(8)) bus ();

    adc_scan_ctrl #(
        .ADC_WIDTH (8),
        .SCAN_DIV  (4),
        .HYST      (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    assign bus.adc_q = bank[bus.adc_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change only at posedge+1, so the falling edge sees a settled handshake.
    always @(negedge clk) begin
        if (!reset && bus.evt_valid && bus.evt_ready) begin
            evq.push_back({bus.evt_chan, bus.evt_value});
        end
    end

    task automatic cycle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        cycle(3);
        n_tests++;
        if (bus.adc_addr !== 3'd0 || bus.host_ack !== 1'b0 || bus.host_data !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_host_side: addr=%0d ack=%b data=%h, want 0/0/00",
                     bus.adc_addr, bus.host_ack, bus.host_data);
        end
        n_tests++;
        if (bus.evt_valid !== 1'b0 || bus.evt_chan !== 3'd0 || bus.evt_value !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_evt_side: valid=%b chan=%0d value=%h, want 0/0/00",
                     bus.evt_valid, bus.evt_chan, bus.evt_value);
        end
        reset      = 1'b0;
        bus.enable = 1'b1;
    endtask

    task automatic test_initial_scan();
        evq.delete();
        cycle(80);
        n_tests++;
        if (evq.size() != 8) begin
            n_fail++;
            $display("FAIL initial_scan_count: got %0d events, want 8", evq.size());
        end
        for (int i = 0; i < 8; i++) begin
            got = (evq.size() > i) ? evq[i] : 11'h7FF;
            exp = {3'(i), 8'h10};
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL initial_scan_evt%0d: got %h, want %h", i, got, exp);
            end
        end
    endtask

    task automatic test_hysteresis();
        evq.delete();
        bank[3] = 8'h11;
        cycle(40);
        n_tests++;
        if (evq.size() != 0) begin
            n_fail++;
            $display("FAIL hyst_small_change: got %0d events, want 0", evq.size());
        end
        bank[3] = 8'h12;
        cycle(40);
        got = (evq.size() > 0) ? evq[0] : 11'h7FF;
        n_tests++;
        if (evq.size() != 1 || got !== {3'd3, 8'h12}) begin
            n_fail++;
            $display("FAIL hyst_threshold: got %0d events first=%h, want 1 event %h",
                     evq.size(), got, {3'd3, 8'h12});
        end
    endtask

    task automatic test_downward_wrap();
        logic [7:0] vals [4];
        logic [2:0] chans [4];
        vals  = '{8'h12, 8'h10, 8'h00, 8'hFF};
        chans = '{3'd5, 3'd5, 3'd1, 3'd1};
        for (int i = 0; i < 4; i++) begin
            evq.delete();
            bank[chans[i]] = vals[i];
            cycle(40);
            got = (evq.size() > 0) ? evq[0] : 11'h7FF;
            exp = {chans[i], vals[i]};
            n_tests++;
            if (evq.size() != 1 || got !== exp) begin
                n_fail++;
                $display("FAIL down_wrap_step%0d: got %0d events first=%h, want 1 event %h",
                         i, evq.size(), got, exp);
            end
        end
    endtask

    task automatic test_backpressure();
        int bad;
        evq.delete();
        bus.evt_ready = 1'b0;
        bank[2] = 8'h40;
        for (int k = 0; k < 40 && !bus.evt_valid; k++) cycle(1);
        n_tests++;
        if (bus.evt_valid !== 1'b1 || bus.evt_chan !== 3'd2 || bus.evt_value !== 8'h40) begin
            n_fail++;
            $display("FAIL bp_offer: valid=%b chan=%0d value=%h, want 1/2/40",
                     bus.evt_valid, bus.evt_chan, bus.evt_value);
        end
        bank[3] = 8'h70;
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            cycle(1);
            if (bus.evt_valid !== 1'b1 || bus.evt_chan !== 3'd2 ||
                bus.evt_value !== 8'h40 || bus.adc_addr !== 3'd2) bad++;
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL bp_stall_stable: %0d unstable cycles, want 0", bad);
        end
        bus.evt_ready = 1'b1;
        cycle(40);
        n_tests++;
        if (evq.size() != 2 || evq[0] !== {3'd2, 8'h40} || evq[1] !== {3'd3, 8'h70}) begin
            n_fail++;
            $display("FAIL bp_release: got %0d events, want 2 events %h then %h",
                     evq.size(), {3'd2, 8'h40}, {3'd3, 8'h70});
        end
    endtask

    task automatic test_enable_gate();
        bus.enable = 1'b0;
        cycle(5);
        evq.delete();
        bank[4] = 8'h90;
        cycle(40);
        n_tests++;
        if (evq.size() != 0) begin
            n_fail++;
            $display("FAIL enable_blocks_polls: got %0d events, want 0", evq.size());
        end
        bus.host_addr = 3'd4;
        bus.host_req  = 1'b1;
        for (int k = 0; k < 10 && !bus.host_ack; k++) cycle(1);
        n_tests++;
        if (bus.host_ack !== 1'b1 || bus.host_data !== 8'h90) begin
            n_fail++;
            $display("FAIL enable_host_read: ack=%b data=%h, want 1/90",
                     bus.host_ack, bus.host_data);
        end
        bus.host_req = 1'b0;
        bus.enable   = 1'b1;
        cycle(40);
        got = (evq.size() > 0) ? evq[0] : 11'h7FF;
        n_tests++;
        if (evq.size() != 1 || got !== {3'd4, 8'h90}) begin
            n_fail++;
            $display("FAIL enable_resume: got %0d events first=%h, want 1 event %h",
                     evq.size(), got, {3'd4, 8'h90});
        end
    endtask

    task automatic test_reset_mid_emit();
        bus.evt_ready = 1'b0;
        bank[6] = 8'h22;
        for (int k = 0; k < 40 && !bus.evt_valid; k++) cycle(1);
        n_tests++;
        if (bus.evt_valid !== 1'b1 || bus.evt_chan !== 3'd6) begin
            n_fail++;
            $display("FAIL rst_emit_setup: valid=%b chan=%0d, want 1/6",
                     bus.evt_valid, bus.evt_chan);
        end
        #2;
        reset = 1'b1;
        #1;
        n_tests++;
        if (bus.evt_valid !== 1'b0 || bus.evt_chan !== 3'd0 || bus.evt_value !== 8'h00 ||
            bus.adc_addr !== 3'd0 || bus.host_data !== 8'h00) begin
            n_fail++;
            $display("FAIL rst_emit_async: valid=%b chan=%0d value=%h addr=%0d hdata=%h, want all 0",
                     bus.evt_valid, bus.evt_chan, bus.evt_value, bus.adc_addr, bus.host_data);
        end
        cycle(1);
        evq.delete();
        bus.evt_ready = 1'b1;
        reset = 1'b0;
        cycle(20);
        got = (evq.size() > 0) ? evq[0] : 11'h7FF;
        n_tests++;
        if (got !== {3'd0, 8'h10}) begin
            n_fail++;
            $display("FAIL rst_emit_reemit: first=%h, want %h", got, {3'd0, 8'h10});
        end
    endtask

    task automatic test_host_priority();
        reset   = 1'b1;
        bank[6] = 8'h66;
        cycle(1);
        reset = 1'b0;
        cycle(3);
        // Divider now sits at terminal count: the tick and the request share this cycle.
        bus.host_addr = 3'd6;
        bus.host_req  = 1'b1;
        cycle(1);
        n_tests++;
        if (bus.adc_addr !== 3'd6 || bus.host_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL host_addr_phase: addr=%0d ack=%b, want 6/0", bus.adc_addr, bus.host_ack);
        end
        cycle(1);
        n_tests++;
        if (bus.host_ack !== 1'b1 || bus.host_data !== 8'h66) begin
            n_fail++;
            $display("FAIL host_ack_phase: ack=%b data=%h, want 1/66", bus.host_ack, bus.host_data);
        end
        bus.host_req = 1'b0;
        cycle(1);
        n_tests++;
        if (bus.host_ack !== 1'b0 || bus.host_data !== 8'h66 || bus.adc_addr !== 3'd0) begin
            n_fail++;
            $display("FAIL host_then_scan: ack=%b data=%h addr=%0d, want 0/66/0",
                     bus.host_ack, bus.host_data, bus.adc_addr);
        end
        cycle(1);
        n_tests++;
        if (bus.evt_valid !== 1'b1 || bus.evt_chan !== 3'd0 || bus.evt_value !== 8'h10) begin
            n_fail++;
            $display("FAIL host_scan_emit: valid=%b chan=%0d value=%h, want 1/0/10",
                     bus.evt_valid, bus.evt_chan, bus.evt_value);
        end
    endtask

    initial begin
        n_tests       = 0;
        n_fail        = 0;
        reset         = 1'b1;
        bus.enable    = 1'b0;
        bus.host_req  = 1'b0;
        bus.host_addr = 3'd0;
        bus.evt_ready = 1'b1;
        for (int i = 0; i < 8; i++) bank[i] = 8'h10;

        test_reset();
        test_initial_scan();
        test_hysteresis();
        test_downward_wrap();
        test_backpressure();
        test_enable_gate();
        test_reset_mid_emit();
        test_host_priority();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/adc_scan_ctrl.md
ADC_SCAN_CTRL -- requirements
Module: adc_scan_ctrl

Interface
REQ-001 SHALL have parameter ADC_WIDTH, default 8, sample width in bits.
REQ-002 SHALL have parameter SCAN_DIV, default 16000, clk cycles between channel polls (>=2).
REQ-003 SHALL have parameter HYST, default 2, minimum absolute change that produces an event (>=1).
REQ-004 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port enable  input  1  permits new scan polls.
REQ-007 SHALL have port adc_addr  output  3  ADC register-bank read address.
REQ-008 SHALL have port adc_q  input  ADC_WIDTH  bank read data, combinational from adc_addr.
REQ-009 SHALL have port host_req  input  1  host single-read request, held until host_ack.
REQ-010 SHALL have port host_addr  input  3  host channel, held with host_req.
REQ-011 SHALL have port host_ack  output  1  one-cycle pulse, host_data valid.
REQ-012 SHALL have port host_data  output  ADC_WIDTH  host read result, held until next ack.
REQ-013 SHALL have port evt_valid  output  1  change event offered.
REQ-014 SHALL have port evt_ready  input  1  consumer accepts event.
REQ-015 SHALL have ports evt_chan (output, 3) and evt_value (output, ADC_WIDTH), event payload, stable while evt_valid.

Function
REQ-016 SHALL use FSM states WAIT, CHECK, EMIT, HOST; all outputs registered.
REQ-017 SHALL run a divider counting SCAN_DIV cycles while enable=1, setting a pending flag at terminal count; divider holds while enable=0.
REQ-018 In WAIT with host_req=1 and host_ack=0: adc_addr<=host_addr, go HOST (host beats pending scan).
REQ-019 In HOST: host_data<=adc_q, host_ack=1 for exactly one cycle, go WAIT; host_req ignored while host_ack=1.
REQ-020 In WAIT with no host request and pending=1: adc_addr<=scan_ptr, clear pending, go CHECK.
REQ-021 In CHECK: diff = |adc_q - last[scan_ptr]| computed in ADC_WIDTH+1 bits, unsigned magnitude.
REQ-022 In CHECK, if seen[scan_ptr]=0 or diff>=HYST: last<=adc_q, seen<=1, evt_chan<=scan_ptr, evt_value<=adc_q, evt_valid<=1, go EMIT; else scan_ptr++ , go WAIT.
REQ-023 In EMIT: on clock with evt_valid&evt_ready, evt_valid<=0, scan_ptr++, go WAIT; payload unchanged until then.
REQ-024 scan_ptr SHALL wrap 7->0; channels polled strictly 0..7 in order.
REQ-025 Ticks during CHECK/EMIT/HOST SHALL set pending once (no counting); extra ticks are dropped.
REQ-026 enable=0 SHALL block new polls only; CHECK/EMIT in progress and host reads complete normally.
REQ-027 Host latency SHALL be 2 cycles from WAIT-sampled host_req to host_ack; host waits while EMIT stalls.

Reset
REQ-028 reset SHALL asynchronously force WAIT, adc_addr=0, scan_ptr=0, divider=0, pending=0, seen=0, last[*]=0, host_ack=0, host_data=0, evt_valid=0, evt_chan=0, evt_value=0, including mid-EMIT.

Structure
REQ-029 Shared package SHALL hold FSM state encoding, channel count 8, channel address width 3.
REQ-030 Divider/pending logic SHALL be sub-module tick_gen (params SCAN_DIV; ports clk, reset, enable, tick).

Verification
REQ-031 SCAN_DIV=4, HYST=2, bank all 0x10, evt_ready=1 after reset -> 8 events chan 0..7 value 0x10, then none.
REQ-032 Chan 3 changes 0x10->0x11 then 0x12 -> no event for 0x11; one event chan 3 value 0x12.
REQ-033 Chan 5 0x12->0x10 (downward) -> event chan 5 value 0x10; 0x00/0xFF wrap gives diff 0xFF, not 1.
REQ-034 Event pending, evt_ready=0 for 20 cycles -> evt_valid/payload stable, scan_ptr frozen; ready=1 -> accepted, next channel polled.
REQ-035 host_req addr 6 coincident with tick in WAIT -> host_ack 2 cycles later with bank[6]; scan of pending channel starts next WAIT cycle.
REQ-036 reset asserted mid-EMIT -> evt_valid=0 same cycle; after release first poll of chan 0 re-emits its value.
